video_timing_tpg: RTL and testbench
===================================

// Module: video_timing_tpg
// PURPOSE
//  720p60 video timing generator plus colour-bar test-pattern source.
//  Runs on the 74.25 MHz PLL clock and drives the HDMI transmitter parallel
//  pins (hsync, vsync, v_clk, data_enable, rgb_data). Frames are gated by a
//  run request, so the transmitter sees only whole frames.
// PARAMETERS
//  H_ACTIVE  1280  active pixels per line
//  H_FP      110   horizontal front porch (clocks)
//  H_SYNC    40    hsync width (clocks)
//  H_BP      220   horizontal back porch (clocks)
//  V_ACTIVE  720   active lines per frame
//  V_FP      5     vertical front porch (lines)
//  V_SYNC    5     vsync width (lines)
//  V_BP      20    vertical back porch (lines)
//  HS_POL    1     hsync active level
//  VS_POL    1     vsync active level
// PORTS
//  clk_in       in   1   pixel clock, 74.25 MHz
//  reset        in   1   asynchronous, active-high reset
//  run          in   1   request frame generation; level-sensitive
//  hsync        out  1   horizontal sync, registered
//  vsync        out  1   vertical sync, registered
//  v_clk        out  1   pixel clock to transmitter, = ~clk_in
//  data_enable  out  1   high during active pixels, registered
//  rgb_data     out  24  {R[7:0],G[7:0],B[7:0]}, registered
//  pix_x        out  11  active x of current rgb_data (0..H_ACTIVE-1)
//  pix_y        out  10  active y of current rgb_data (0..V_ACTIVE-1)
//  frame_start  out  1   one-cycle pulse with first active pixel (0,0)
// BEHAVIOUR
//  - Async reset: state=IDLE, h_cnt=v_cnt=0; hsync=~HS_POL, vsync=~VS_POL;
//    data_enable=0, rgb_data=0, pix_x=pix_y=0, frame_start=0.
//  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (1650); V_TOTAL = 750.
//  - Line order: active, FP, sync, BP. Same order for frame lines.
//    h_cnt wraps H_TOTAL-1 -> 0 and advances v_cnt.
//    v_cnt wraps V_TOTAL-1 -> 0.
//  - FSM: IDLE, RUN, DRAIN.
//    IDLE -> RUN when run=1; counters start at (0,0) on the next cycle.
//    RUN -> DRAIN when run=0.
//    DRAIN -> RUN if run=1 again before the frame ends.
//    DRAIN -> IDLE on the cycle h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1.
//    In IDLE the counters hold at 0 and all outputs stay at reset values.
//  - Outputs are registered from the counters. Latency is 1 clock:
//    counter state (h,v) appears on the pins 1 cycle later.
//  - hsync asserted while H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
//    vsync asserted while V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC,
//    for whole lines (changes only at h_cnt=0).
//  - data_enable = (h_cnt<H_ACTIVE)&&(v_cnt<V_ACTIVE).
//    Outside active video: rgb_data=0, pix_x/pix_y hold their last value.
//  - Colour bars: 8 bars, each H_ACTIVE/8 = 160 wide, in this order:
//    white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00,
//    magenta FF00FF, red FF0000, blue 0000FF, black 000000.
//    Bar index comes from a bar-width counter (no divider). It resets at
//    h_cnt=0 and saturates at 7.
//  - frame_start is high together with data_enable for pixel (0,0) only.
//  - A reset during a frame aborts the frame immediately. No partial-frame
//    recovery; the next frame starts from (0,0) once run=1.
// CONFIGURATION
//  TPG_GRID_EN defined: where pix_x[5:0]==0 or pix_y[5:0]==0 in active
//    video, rgb_data=FFFFFF, overriding the bar colour. This gives a 64-pixel
//    grid. Timing is unchanged.
//  TPG_GRID_EN undefined: plain colour bars only, and no grid logic is
//    synthesised.
// TESTING
//  1 reset=1 mid-line, with run=1 -> same/next edge: hsync=0, vsync=0,
//    data_enable=0, rgb_data=0. These hold while reset=1.
//  2 run 0->1 -> exactly 1650 clocks between hsync rising edges.
//    hsync high for 40 clocks. data_enable high for 1280 clocks per line.
//  3 Full frame -> 750 lines per vsync period; vsync high for 5 lines.
//    720 lines with data_enable; frame_start pulses once per 1237500 clocks.
//  4 Pixel checks -> pix_x=0: FFFFFF; 159: FFFFFF; 160: FFFF00;
//    1119: 0000FF; 1120..1279: 000000. Do this check with TPG_GRID_EN off.
//  5 run dropped at line 100 -> frame completes all 750 lines, then IDLE
//    with outputs at reset values. Re-assert run -> next frame_start occurs
//    2 clocks later.
//  6 TPG_GRID_EN on -> (64,5)=FFFFFF, (65,64)=FFFFFF, (65,5)=FFFFFF (bar 0),
//    (200,5)=FFFF00. Timing identical to test 2.

Source files
------------

// File: rtl/video_timing_tpg.sv
// 720p60 video timing generator with a colour-bar test pattern; whole frames only.
// Optional build macro TPG_GRID_EN overlays a 64-pixel white grid on the bars.
module video_timing_tpg #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        run,
  output logic        hsync,
  output logic        vsync,
  output logic        v_clk,
  output logic        data_enable,
  output logic [23:0] rgb_data,
  output logic [10:0] pix_x,
  output logic [9:0]  pix_y,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0] HS_BEG   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] BAR_LAST = 11'(H_ACTIVE / 8 - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0]  VS_BEG   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t      state_q, state_d;
  logic [10:0] h_cnt_q, h_cnt_d;
  logic [9:0]  v_cnt_q, v_cnt_d;
  logic [10:0] bar_cnt_q, bar_cnt_d;
  logic [2:0]  bar_idx_q, bar_idx_d;

  logic        hsync_q, vsync_q, de_q, fs_q;
  logic [23:0] rgb_q;
  logic [10:0] pix_x_q;
  logic [9:0]  pix_y_q;

  logic        line_end, frame_end;
  logic        hs_c, vs_c, de_c, fs_c;
  logic [23:0] rgb_c;

  function automatic logic [23:0] bar_rgb(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_rgb = 24'hFFFFFF;
      3'd1:    bar_rgb = 24'hFFFF00;
      3'd2:    bar_rgb = 24'h00FFFF;
      3'd3:    bar_rgb = 24'h00FF00;
      3'd4:    bar_rgb = 24'hFF00FF;
      3'd5:    bar_rgb = 24'hFF0000;
      3'd6:    bar_rgb = 24'h0000FF;
      default: bar_rgb = 24'h000000;
    endcase
  endfunction

  assign line_end  = (h_cnt_q == H_LAST);
  assign frame_end = line_end && (v_cnt_q == V_LAST);

  always_comb begin
    state_d   = state_q;
    h_cnt_d   = h_cnt_q;
    v_cnt_d   = v_cnt_q;
    bar_cnt_d = bar_cnt_q;
    bar_idx_d = bar_idx_q;
    case (state_q)
      IDLE:    if (run) state_d = RUN;
      RUN:     if (!run) state_d = DRAIN;
      DRAIN: begin
        if (run)            state_d = RUN;
        else if (frame_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Counters free-run in RUN and DRAIN; IDLE parks them at the frame origin.
    if (state_q != IDLE) begin
      if (line_end) begin
        h_cnt_d   = '0;
        bar_cnt_d = '0;
        bar_idx_d = '0;
        v_cnt_d   = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
      end else begin
        h_cnt_d = h_cnt_q + 11'd1;
        if (bar_cnt_q == BAR_LAST) begin
          bar_cnt_d = '0;
          if (bar_idx_q != 3'd7) bar_idx_d = bar_idx_q + 3'd1;
        end else begin
          bar_cnt_d = bar_cnt_q + 11'd1;
        end
      end
    end
  end

  always_comb begin
    hs_c  = (h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END);
    vs_c  = (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END);
    de_c  = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    fs_c  = de_c && (h_cnt_q == '0) && (v_cnt_q == '0);
    rgb_c = '0;
    if (de_c) begin
      rgb_c = bar_rgb(bar_idx_q);
`ifdef TPG_GRID_EN
      if ((h_cnt_q[5:0] == 6'd0) || (v_cnt_q[5:0] == 6'd0)) rgb_c = 24'hFFFFFF;
`endif
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      bar_cnt_q <= '0;
      bar_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      bar_cnt_q <= bar_cnt_d;
      bar_idx_q <= bar_idx_d;
    end
  end

  // Pin registers: one clock behind the counters.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      hsync_q <= ~HS_POL;
      vsync_q <= ~VS_POL;
      de_q    <= 1'b0;
      fs_q    <= 1'b0;
      rgb_q   <= '0;
      pix_x_q <= '0;
      pix_y_q <= '0;
    end else if (state_q == IDLE) begin
      hsync_q <= ~HS_POL;
      vsync_q <= ~VS_POL;
      de_q    <= 1'b0;
      fs_q    <= 1'b0;
      rgb_q   <= '0;
      pix_x_q <= '0;
      pix_y_q <= '0;
    end else begin
      hsync_q <= hs_c ? HS_POL : ~HS_POL;
      vsync_q <= vs_c ? VS_POL : ~VS_POL;
      de_q    <= de_c;
      fs_q    <= fs_c;
      rgb_q   <= rgb_c;
      if (de_c) begin
        pix_x_q <= h_cnt_q;
        pix_y_q <= v_cnt_q;
      end
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign data_enable = de_q;
  assign frame_start = fs_q;
  assign rgb_data    = rgb_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign v_clk       = ~clk_in;

endmodule

// File: tb/tb_video_timing_tpg.sv
// Bench for video_timing_tpg on a shrunken raster: cycle scoreboard plus timing/pixel checks.
module tb_video_timing_tpg;

  localparam int H_ACTIVE = 128;
  localparam int H_FP     = 6;
  localparam int H_SYNC   = 4;
  localparam int H_BP     = 10;
  localparam int V_ACTIVE = 8;
  localparam int V_FP     = 2;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 3;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FRAME    = H_TOTAL * V_TOTAL;
  localparam int BAR_W    = H_ACTIVE / 8;

  typedef logic [49:0] vec_t;
  localparam vec_t RST_VEC = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0, 11'h0, 10'h0};

  logic        clk_in = 1'b0;
  logic        reset, run;
  logic        hsync, vsync, v_clk, data_enable, frame_start;
  logic [23:0] rgb_data;
  logic [10:0] pix_x;
  logic [9:0]  pix_y;

  always #5 clk_in = ~clk_in;

  video_timing_tpg #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut (
    .clk_in(clk_in), .reset(reset), .run(run),
    .hsync(hsync), .vsync(vsync), .v_clk(v_clk), .data_enable(data_enable),
    .rgb_data(rgb_data), .pix_x(pix_x), .pix_y(pix_y), .frame_start(frame_start)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: state 0=idle 1=run 2=drain, counters and held pixel coordinates.
  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
  int   m_st = 0, mh = 0, mv = 0, m_px = 0, m_py = 0;
  bit   sb_on = 0;
  vec_t exp_q [$];

  function automatic vec_t model_out();
    bit hs, vs, de, fs;
    int bi;
    logic [23:0] rgb;
    int px, py;
    if (m_st == 0) return RST_VEC;
    de  = (mh < H_ACTIVE) && (mv < V_ACTIVE);
    hs  = (mh >= H_ACTIVE + H_FP) && (mh < H_ACTIVE + H_FP + H_SYNC);
    vs  = (mv >= V_ACTIVE + V_FP) && (mv < V_ACTIVE + V_FP + V_SYNC);
    fs  = de && (mh == 0) && (mv == 0);
    bi  = mh / BAR_W;
    if (bi > 7) bi = 7;
    rgb = de ? bars[bi] : 24'h0;
`ifdef TPG_GRID_EN
    if (de && ((mh % 64 == 0) || (mv % 64 == 0))) rgb = 24'hFFFFFF;
`endif
    px = de ? mh : m_px;
    py = de ? mv : m_py;
    return {1'b1, hs, vs, de, fs, rgb, 11'(px), 10'(py)};
  endfunction

  task automatic model_reset();
    m_st = 0; mh = 0; mv = 0; m_px = 0; m_py = 0;
  endtask

  always @(posedge clk_in) begin
    vec_t e;
    bit   frame_end;
    if (reset) begin
      model_reset();
      exp_q.push_back(RST_VEC);
    end else begin
      e = model_out();
      exp_q.push_back(e);
      if (m_st == 0) begin
        m_px = 0; m_py = 0;
        if (run) m_st = 1;
      end else begin
        if (e[46]) begin m_px = mh; m_py = mv; end
        frame_end = (mh == H_TOTAL - 1) && (mv == V_TOTAL - 1);
        if (m_st == 1 && !run) m_st = 2;
        else if (m_st == 2 && run) m_st = 1;
        else if (m_st == 2 && frame_end) m_st = 0;
        if (mh == H_TOTAL - 1) begin
          mh = 0;
          mv = (mv == V_TOTAL - 1) ? 0 : mv + 1;
        end else begin
          mh = mh + 1;
        end
      end
    end
    sb_on = 1;
  end

  // Async reset overrides whatever was queued for the pins.
  always @(posedge reset) begin
    if (sb_on) begin
      model_reset();
      for (int i = 0; i < exp_q.size(); i++) exp_q[i] = RST_VEC;
    end
  end

  int cyc = 0;
  int last_hs = -1, hs_run = 0, hs_period = 0, hs_width = 0;
  int de_run = 0, de_width = 0, de_lines = 0, frame_lines = 0;
  int last_fs = -1, fs_period = 0;
  int last_vs = -1, vs_run = 0, vs_period = 0, vs_width = 0;
  bit p_hs = 0, p_de = 0, p_vs = 0;

  always @(negedge clk_in) begin
    vec_t e;
    if (sb_on) begin
      if (exp_q.size() == 0) chk("sb_empty", 0, 1);
      else begin
        e = exp_q.pop_front();
        chk("pins", {v_clk, hsync, vsync, data_enable, frame_start, rgb_data, pix_x, pix_y}, e);
      end
    end
    cyc++;
    if (reset) begin
      last_hs = -1; last_fs = -1; last_vs = -1;
      hs_run = 0; de_run = 0; vs_run = 0; de_lines = 0;
    end else begin
      if (hsync && !p_hs) begin
        if (last_hs >= 0) hs_period = cyc - last_hs;
        last_hs = cyc;
      end
      if (hsync) hs_run++;
      else if (p_hs) begin hs_width = hs_run; hs_run = 0; end
      if (data_enable) de_run++;
      else if (p_de) begin de_width = de_run; de_run = 0; de_lines++; end
      if (vsync && !p_vs) begin
        if (last_vs >= 0) vs_period = cyc - last_vs;
        last_vs = cyc;
      end
      if (vsync) vs_run++;
      else if (p_vs) begin vs_width = vs_run; vs_run = 0; end
      if (frame_start) begin
        if (last_fs >= 0) fs_period = cyc - last_fs;
        last_fs = cyc;
        frame_lines = de_lines;
        de_lines = 0;
      end
      if (data_enable && pix_y == 10'd1) begin
        case (pix_x)
          11'd0:   chk("px0",   rgb_data, 24'hFFFFFF);
          11'd15:  chk("px15",  rgb_data, 24'hFFFFFF);
          11'd16:  chk("px16",  rgb_data, 24'hFFFF00);
`ifdef TPG_GRID_EN
          11'd64:  chk("px64",  rgb_data, 24'hFFFFFF);
`else
          11'd64:  chk("px64",  rgb_data, 24'hFF00FF);
`endif
          11'd111: chk("px111", rgb_data, 24'h0000FF);
          11'd112: chk("px112", rgb_data, 24'h000000);
          11'd127: chk("px127", rgb_data, 24'h000000);
          default: ;
        endcase
      end
`ifdef TPG_GRID_EN
      if (data_enable && pix_y == 10'd5 && pix_x == 11'd64) chk("grid_64_5", rgb_data, 24'hFFFFFF);
      if (data_enable && pix_y == 10'd0 && pix_x == 11'd65) chk("grid_65_0", rgb_data, 24'hFFFFFF);
      if (data_enable && pix_y == 10'd5 && pix_x == 11'd65) chk("grid_65_5", rgb_data, 24'hFF00FF);
      if (data_enable && pix_y == 10'd5 && pix_x == 11'd20) chk("grid_20_5", rgb_data, 24'hFFFF00);
`endif
    end
    p_hs = hsync; p_de = data_enable; p_vs = vsync;
  end

  task automatic wait_model(input int st, input int v, input int h, input int lim, input string tag);
    int k;
    for (k = 0; k < lim; k++) begin
      @(negedge clk_in);
      if (m_st == st && mv == v && mh == h) break;
    end
    chk(tag, k < lim, 1);
  endtask

  task automatic fs_latency(input string tag);
    int k;
    for (k = 1; k <= 10; k++) begin
      @(posedge clk_in);
      #1;
      if (frame_start) break;
    end
    chk(tag, k, 2);
  endtask

  initial begin
    reset = 1'b1;
    run   = 1'b0;
    repeat (3) @(negedge clk_in);
    chk("rst_hsync", hsync, 0);
    chk("rst_vsync", vsync, 0);
    chk("rst_de",    data_enable, 0);
    chk("rst_rgb",   rgb_data, 0);
    reset = 1'b0;
    @(negedge clk_in);
    run = 1'b1;
    repeat (2 * FRAME + 500) @(negedge clk_in);
    chk("hs_period", hs_period, H_TOTAL);
    chk("hs_width",  hs_width,  H_SYNC);
    chk("de_width",  de_width,  H_ACTIVE);
    chk("vs_period", vs_period, FRAME);
    chk("vs_width",  vs_width,  V_SYNC * H_TOTAL);
    chk("fs_period", fs_period, FRAME);
    chk("frame_lines", frame_lines, V_ACTIVE);

    // Reset in the middle of an active line with run held high.
    wait_model(1, 2, 50, 2 * FRAME, "tmo_reset_point");
    #2 reset = 1'b1;
    #1;
    chk("midrst_hsync", hsync, 0);
    chk("midrst_vsync", vsync, 0);
    chk("midrst_de",    data_enable, 0);
    chk("midrst_rgb",   rgb_data, 0);
    repeat (3) @(negedge clk_in);
    chk("hold_de",  data_enable, 0);
    chk("hold_rgb", rgb_data, 0);
    reset = 1'b0;
    fs_latency("restart_latency");

    // Drop run partway through the frame: it must complete, then go idle.
    wait_model(1, 3, 10, 2 * FRAME, "tmo_drain_point");
    run = 1'b0;
    begin
      int k;
      for (k = 0; k < FRAME + 10; k++) begin
        @(negedge clk_in);
        if (m_st == 0) break;
      end
      chk("tmo_drain_idle", k < FRAME + 10, 1);
    end
    repeat (3) @(negedge clk_in);
    chk("drain_lines", de_lines, V_ACTIVE);
    chk("idle_hsync",  hsync, 0);
    chk("idle_vsync",  vsync, 0);
    chk("idle_de",     data_enable, 0);
    chk("idle_pix",    {pix_x, pix_y}, 0);
    @(negedge clk_in);
    run = 1'b1;
    fs_latency("rerun_latency");

    // Brief run drop that is withdrawn before the frame ends.
    wait_model(1, 4, 0, 2 * FRAME, "tmo_blip_point");
    run = 1'b0;
    repeat (200) @(negedge clk_in);
    run = 1'b1;
    repeat (2 * FRAME) @(negedge clk_in);
    chk("fs_period_resume", fs_period, FRAME);
    chk("hs_period_resume", hs_period, H_TOTAL);

    run = 1'b0;
    repeat (FRAME + 20) @(negedge clk_in);
    chk("final_idle_de", data_enable, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
